// File: rtl/spm_pkg.sv
// Shared constants and FSM state type for the serial-parallel multiplier.
package spm_pkg;

    localparam int SPM_WIDTH  = 32;
    localparam int SPM_PWIDTH = 2 * SPM_WIDTH;
    localparam int SPM_CNT_W  = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } spm_state_e;

endpackage

// File: rtl/spm_csa_cell.sv
// One carry-save cell of the multiplier array: registered sum and carry,
// the carry is recirculated into the same cell on the next cycle.
module spm_csa_cell (
    input  logic clk,
    input  logic clr,
    input  logic en,
    input  logic a,
    input  logic y,
    output logic sum,
    output logic carry
);

    logic sum_q, sum_d;
    logic carry_q, carry_d;

    always_comb begin
        sum_d   = a ^ y ^ carry_q;
        carry_d = (a & y) | (a & carry_q) | (y & carry_q);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            sum_q   <= 1'b0;
            carry_q <= 1'b0;
        end else if (en) begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign sum   = sum_q;
    assign carry = carry_q;

endmodule

// File: rtl/spm.sv
// Serial-parallel multiplier top. Define SPM_SIGNED_EN for two's-complement operands.
// state | meaning
// IDLE  | waiting for start
// BUSY  | 2*WIDTH cycles: WIDTH operand bits then WIDTH flush bits
// DONE  | done pulse, P valid
module spm
    import spm_pkg::*;
#(
    parameter int WIDTH = SPM_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     MP,
    input  logic [WIDTH-1:0]     MC,
    input  logic                 start,
    output logic [2*WIDTH-1:0]   P,
    output logic                 done
);

    localparam int PW = 2 * WIDTH;
    localparam logic [SPM_CNT_W-1:0] CNT_LAST = SPM_CNT_W'(PW - 1);

    spm_state_e              state_q;
    logic [SPM_CNT_W-1:0]    cnt_q;
    logic [WIDTH-1:0]        mp_q;
    logic [WIDTH-1:0]        mc_q;
    logic [PW-3:0]           prod_q;
    logic [PW-1:0]           p_q;
    logic                    done_q;

    logic [WIDTH-1:0]        a_w, y_w, sum_w, carry_w;
    logic                    load, clr_arr, en_arr, mp_fill, p_bit;
    logic [PW-1:0]           result;

`ifdef SPM_SIGNED_EN
    logic [WIDTH-1:0]        mp_hold_q;
    assign mp_fill = mp_q[WIDTH-1];
`else
    assign mp_fill = 1'b0;
`endif

    assign load    = start && (rst || (state_q == IDLE));
    assign clr_arr = rst || load;
    assign en_arr  = (state_q == BUSY);

    assign a_w   = mc_q & {WIDTH{mp_q[0]}};
    assign y_w   = {1'b0, sum_w[WIDTH-1:1]};
    assign p_bit = a_w[0] ^ y_w[0] ^ carry_w[0];

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        spm_csa_cell u_cell (
            .clk   (clk),
            .clr   (clr_arr),
            .en    (en_arr),
            .a     (a_w[i]),
            .y     (y_w[i]),
            .sum   (sum_w[i]),
            .carry (carry_w[i])
        );
    end

    // On the last BUSY edge bit PW-1 is still combinational and bit PW-2 sits in cell 0.
`ifdef SPM_SIGNED_EN
    // Array works on MC as unsigned; a negative MC needs MP * 2^WIDTH taken back off.
    assign result = {p_bit, sum_w[0], prod_q}
                    - (mc_q[WIDTH-1] ? {mp_hold_q, {WIDTH{1'b0}}} : {PW{1'b0}});
`else
    assign result = {p_bit, sum_w[0], prod_q};
`endif

    always_ff @(posedge clk) begin
        if (load) begin
            state_q <= BUSY;
            cnt_q   <= '0;
            mp_q    <= MP;
            mc_q    <= MC;
            prod_q  <= '0;
            done_q  <= 1'b0;
`ifdef SPM_SIGNED_EN
            mp_hold_q <= MP;
`endif
            if (rst) begin
                p_q <= '0;
            end
        end else if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prod_q  <= '0;
            p_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                end
                BUSY: begin
                    cnt_q  <= cnt_q + SPM_CNT_W'(1);
                    mp_q   <= {mp_fill, mp_q[WIDTH-1:1]};
                    prod_q <= {sum_w[0], prod_q[PW-3:1]};
                    if (cnt_q == CNT_LAST) begin
                        state_q <= DONE;
                        p_q     <= result;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign P    = p_q;
    assign done = done_q;

endmodule

// File: tb/tb_spm.sv
// Directed self-checking bench for spm; build with SPM_SIGNED_EN to select the signed vector set.
module tb_spm;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] MP, MC;
    logic        start;
    logic [63:0] P;
    logic        done;

    int n_pass  = 0;
    int n_total = 0;
    logic [63:0] last_p;

    typedef struct {
        string       name;
        logic [31:0] mp;
        logic [31:0] mc;
        logic [63:0] p;
    } vec_t;

    vec_t vecs[8];

    spm dut (
        .clk   (clk),
        .rst   (rst),
        .MP    (MP),
        .MC    (MC),
        .start (start),
        .P     (P),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Launch one multiply and follow it to completion; optional reset on the
    // launch edge and an optional ignored start re-pulse partway through BUSY.
    task automatic run_op(input string nm, input logic [31:0] mp, input logic [31:0] mc,
                          input logic [63:0] exp, input bit with_rst, input int repulse);
        int cycles;
        MP    = mp;
        MC    = mc;
        start = 1'b1;
        if (with_rst) rst = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        rst   = 1'b0;
        if (with_rst) chk({nm, " P cleared"}, P, 64'h0);
        cycles = 0;
        while (!done && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
            if (cycles == repulse) begin
                MP    = 32'h5;
                MC    = 32'h5;
                start = 1'b1;
            end
            if (cycles == repulse + 1) start = 1'b0;
            if (cycles == 20) chk({nm, " P held during BUSY"}, P, last_p);
        end
        chk({nm, " latency"}, 64'(cycles), 64'd64);
        chk({nm, " P"}, P, exp);
        @(posedge clk);
        #1;
        chk({nm, " done one cycle"}, 64'(done), 64'd0);
        last_p = exp;
    endtask

    initial begin
        int seen;
`ifdef SPM_SIGNED_EN
        vecs[0] = '{"neg2x3",     32'hFFFFFFFE, 32'h00000003, 64'hFFFFFFFFFFFFFFFA};
        vecs[1] = '{"m1xm1",      32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001};
        vecs[2] = '{"zero",       32'h00000000, 32'h12345678, 64'h0000000000000000};
        vecs[3] = '{"3xneg2",     32'h00000003, 32'hFFFFFFFE, 64'hFFFFFFFFFFFFFFFA};
        vecs[4] = '{"minx2",      32'h80000000, 32'h00000002, 64'hFFFFFFFF00000000};
        vecs[5] = '{"minxmin",    32'h80000000, 32'h80000000, 64'h4000000000000000};
        vecs[6] = '{"m1x5",       32'hFFFFFFFF, 32'h00000005, 64'hFFFFFFFFFFFFFFFB};
        vecs[7] = '{"maxxmax",    32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF00000001};
`else
        vecs[0] = '{"allones",    32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001};
        vecs[1] = '{"zero",       32'h00000000, 32'h12345678, 64'h0000000000000000};
        vecs[2] = '{"onexmax",    32'h00000001, 32'hFFFFFFFF, 64'h00000000FFFFFFFF};
        vecs[3] = '{"halfword",   32'h00010000, 32'h00010000, 64'h0000000100000000};
        vecs[4] = '{"maxx2",      32'hFFFFFFFF, 32'h00000002, 64'h00000001FFFFFFFE};
        vecs[5] = '{"msbxmsb",    32'h80000000, 32'h80000000, 64'h4000000000000000};
        vecs[6] = '{"identity",   32'h12345678, 32'h00000001, 64'h0000000012345678};
        vecs[7] = '{"7x9",        32'h00000007, 32'h00000009, 64'h000000000000003F};
`endif

        rst    = 1'b1;
        start  = 1'b0;
        MP     = '0;
        MC     = '0;
        last_p = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset P", P, 64'h0);
        chk("reset done", 64'(done), 64'd0);

        run_op("rst_and_start", 32'd2, 32'd3, 64'h6, 1'b1, -10);

        for (int i = 0; i < 8; i++)
            run_op(vecs[i].name, vecs[i].mp, vecs[i].mc, vecs[i].p, 1'b0, -10);

        run_op("repulse_ignored", 32'd7, 32'd9, 64'h3F, 1'b0, 10);

        // Abort mid-operation: no done pulse, P cleared, then a normal run.
        MP    = 32'hFFFFFFFF;
        MC    = 32'hFFFFFFFF;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort P", P, 64'h0);
        chk("abort done", 64'(done), 64'd0);
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        chk("abort no done", 64'(seen), 64'd0);
        last_p = 64'h0;
        run_op("after_abort", 32'd2, 32'd3, 64'h6, 1'b0, -10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
